// File: rtl/hram_slot_arbiter_if.sv
// Requester/controller bus of the HyperRAM slot arbiter.
//   m_req/m_ack/m_we/m_a/m_d/m_q : packed per-master request side, master i at
//                                  slice i (m_a[i*abits +: abits], etc.)
//   s_req/s_ack/s_we/s_a/s_d/s_q : single request port toward the controller
//   busy                         : a grant is outstanding
// modport master : the arbiter itself (drives s_*, m_ack, m_q, busy)
// modport slave  : the environment (requesters plus controller)
interface hram_slot_arbiter_if #(
  parameter int masters = 3,
  parameter int abits   = 24,
  parameter int dbits   = 8
);
  logic [masters-1:0]       m_req;
  logic [masters-1:0]       m_ack;
  logic [masters-1:0]       m_we;
  logic [masters*abits-1:0] m_a;
  logic [masters*dbits-1:0] m_d;
  logic [masters*dbits-1:0] m_q;
  logic                     s_req;
  logic                     s_ack;
  logic                     s_we;
  logic [abits-1:0]         s_a;
  logic [dbits-1:0]         s_d;
  logic [dbits-1:0]         s_q;
  logic                     busy;

  modport master (
    input  m_req, m_we, m_a, m_d, s_ack, s_q,
    output m_ack, m_q, s_req, s_we, s_a, s_d, busy
  );

  modport slave (
    output m_req, m_we, m_a, m_d, s_ack, s_q,
    input  m_ack, m_q, s_req, s_we, s_a, s_d, busy
  );
endinterface

// File: rtl/hram_slot_arbiter.sv
// HyperRAM slot arbiter: shares one controller port among several masters.
// Master 0 is urgent and always wins; masters 1..masters-1 are served
// round-robin, but only while the next predicted phi2 tick is far enough
// away that a background access cannot push an urgent one past the C64
// cycle deadline.
// Ports:
//   clk      system clock
//   reset_n  synchronous active-low reset (controller shares it)
//   phi2tick one-cycle pulse per C64 cycle, used to learn the phi2 period
//   bus      hram_slot_arbiter_if.master (requester side + controller side)

// Per-master read-data holding register.
module hram_slot_lane #(
  parameter int dbits = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [dbits-1:0] d,
  output logic [dbits-1:0] q
);
  always_ff @(posedge clk) begin
    if (!reset_n)  q <= '0;
    else if (load) q <= d;
  end
endmodule

module hram_slot_arbiter #(
  parameter int masters      = 3,
  parameter int abits        = 24,
  parameter int dbits        = 8,
  parameter int guard_cycles = 12,
  parameter int cbits        = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              phi2tick,
  hram_slot_arbiter_if.master bus
);
  localparam int               IW    = (masters > 1) ? $clog2(masters) : 1;
  localparam logic [cbits-1:0] CMAX  = '1;
  localparam logic [cbits-1:0] GUARD = cbits'(guard_cycles);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t              state, state_nx;
  logic [IW-1:0]       rr_ptr, idx, win;
  logic [cbits-1:0]    cnt, period;
  logic                valid;
  logic                window_open, grant;
  logic [masters-1:0]  elig, ack_r;
  logic                s_req_r, s_we_r, busy_r;
  logic [abits-1:0]    s_a_r;
  logic [dbits-1:0]    s_d_r;
  logic [masters-1:0][dbits-1:0] q_arr;

  assign bus.m_ack = ack_r;
  assign bus.s_req = s_req_r;
  assign bus.s_we  = s_we_r;
  assign bus.s_a   = s_a_r;
  assign bus.s_d   = s_d_r;
  assign bus.busy  = busy_r;
  assign bus.m_q   = q_arr;

  // cnt>=period first, so period-cnt cannot wrap when the tick is late.
  assign window_open = !valid || (cnt >= period) || ((period - cnt) > GUARD);

  // A master whose ack is on the bus this cycle is not yet re-requesting.
  assign elig = bus.m_req & ~ack_r;

  // Winner select: master 0 unconditionally, else round-robin over 1..masters-1
  // starting after rr_ptr, only while the guard window is open.
  always_comb begin
    int j;
    j     = 0;
    grant = 1'b0;
    win   = '0;
    if (elig[0]) begin
      grant = 1'b1;
    end else if (window_open) begin
      for (int k = 1; k < masters; k++) begin
        j = ((int'(rr_ptr) - 1 + k) % (masters - 1)) + 1;
        if (!grant && elig[j]) begin
          grant = 1'b1;
          win   = IW'(j);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (grant)     state_nx = BUSY;
      BUSY:    if (bus.s_ack) state_nx = DONE;
      DONE:                   state_nx = IDLE;
      default:                state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s_req_r <= 1'b0;
      s_we_r  <= 1'b0;
      s_a_r   <= '0;
      s_d_r   <= '0;
      ack_r   <= '0;
      busy_r  <= 1'b0;
      idx     <= '0;
      rr_ptr  <= IW'(masters - 1);
      cnt     <= '0;
      period  <= '0;
      valid   <= 1'b0;
    end else begin
      ack_r <= '0;

      // phi2 period learning; a saturated count means the tick was lost,
      // so the measured interval is meaningless and the guard is disabled.
      if (phi2tick) begin
        cnt    <= '0;
        period <= cnt;
        valid  <= (cnt != CMAX);
      end else begin
        if (cnt != CMAX)         cnt   <= cnt + 1'b1;
        if (cnt >= CMAX - 1'b1)  valid <= 1'b0;
      end

      case (state)
        IDLE: if (grant) begin
          idx     <= win;
          s_we_r  <= bus.m_we[win];
          s_a_r   <= bus.m_a[win*abits +: abits];
          s_d_r   <= bus.m_d[win*dbits +: dbits];
          s_req_r <= 1'b1;
          busy_r  <= 1'b1;
          if (win != '0) rr_ptr <= win;
        end
        BUSY: if (bus.s_ack) begin
          s_req_r    <= 1'b0;
          ack_r[idx] <= 1'b1;
        end
        DONE: busy_r <= 1'b0;
        default: ;
      endcase
    end
  end

  // Read data is captured on every completion, writes included.
  for (genvar i = 0; i < masters; i++) begin : g_lane
    hram_slot_lane #(.dbits(dbits)) u_lane (
      .clk     (clk),
      .reset_n (reset_n),
      .load    ((state == BUSY) && bus.s_ack && (idx == IW'(i))),
      .d       (bus.s_q),
      .q       (q_arr[i])
    );
  end
endmodule
